// File: rtl/clink_pkg.sv
// +----------------------------------------------------------------------------+
// | clink_pkg: shared types, constants and parameter checks for the            |
// | Camera Link frame packer.                                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package clink_pkg;

  localparam int PIX_CONT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_FV_LOW  = 3'd1,
    ST_WAIT_FV_HIGH = 3'd2,
    ST_CAPTURE      = 3'd3,
    ST_FLUSH        = 3'd4
  } state_t;

  // Pixel containers per stream beat.
  function automatic int ppb(input int data_w);
    return data_w / PIX_CONT_W;
  endfunction

  function automatic bit cfg_legal(input int taps, input int data_w);
    int p;
    p = data_w / PIX_CONT_W;
    return ((taps == 1) || (taps == 2) || (taps == 4) || (taps == 8)) &&
           ((data_w % PIX_CONT_W) == 0) && (p >= taps) && ((p % taps) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clink_sync_fifo.sv
// +----------------------------------------------------------------------------+
// | clink_sync_fifo: single-clock first-word-fall-through FIFO.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module clink_sync_fifo #(
  parameter int WIDTH = 130,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_rd_ok;
  logic             w_wr_ok;

  assign empty   = (r_count == '0);
  assign full    = (r_count == FULL_CNT);
  assign w_rd_ok = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign w_wr_ok = wr_en & (~full | w_rd_ok);
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/clink_frame_packer.sv
// +----------------------------------------------------------------------------+
// | clink_frame_packer: armed Camera Link frame capture, pixel packing into    |
// | AXI-Stream beats, geometry check and overflow flag. ROI: CLINK_PACKER_ROI_EN|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module clink_frame_packer
  import clink_pkg::*;
#(
  parameter int TAPS       = 2,
  parameter int PIXEL_W    = 12,
  parameter int DATA_W     = 128,
  parameter int COORD_W    = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk_pixel,
  input  logic                    clk_pixel_reset,
  input  logic                    arm,
  input  logic                    cfg_continuous,
  input  logic [COORD_W-1:0]      cfg_width,
  input  logic [COORD_W-1:0]      cfg_height,
  input  logic [COORD_W-1:0]      cfg_roi_x,
  input  logic [COORD_W-1:0]      cfg_roi_y,
  input  logic [COORD_W-1:0]      cfg_roi_w,
  input  logic [COORD_W-1:0]      cfg_roi_h,
  input  logic                    fval,
  input  logic                    lval,
  input  logic                    dval,
  input  logic [TAPS*PIXEL_W-1:0] pix_data,
  output logic [DATA_W-1:0]       m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic                    image_end,
  output logic                    busy,
  output logic                    overflow,
  output logic                    size_err,
  output logic [15:0]             frame_cnt
);

  localparam int PPB    = ppb(DATA_W);
  localparam int SLOT_W = (PPB > 1) ? $clog2(PPB) : 1;
  localparam int BEAT_W = DATA_W + 2;

  if (!cfg_legal(TAPS, DATA_W)) begin : g_bad_cfg
    $error("clink_frame_packer: DATA_W/16 must be a multiple of TAPS (1,2,4,8)");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_in_capture;
  logic                w_flush;
  logic                w_sof;
  logic                w_fval_fall;
  logic                w_lval_fall;
  logic                w_valid_pix;
  logic                w_accept;
  logic                w_fill;
  logic                w_roi_hit;
  logic                r_lval_d;
  logic [COORD_W-1:0]  r_pix_cnt;
  logic [COORD_W-1:0]  r_line_cnt;
  logic [COORD_W-1:0]  w_lines;
  logic                w_size_set;
  logic [DATA_W-1:0]   r_pack;
  logic [DATA_W-1:0]   w_pack_nxt;
  logic [SLOT_W-1:0]   r_slot;
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_vld;
  logic                r_tail;
  logic                r_first;
  logic                w_push;
  logic                w_push_last;
  logic [DATA_W-1:0]   w_push_data;
  logic                r_push;
  logic                r_push_last;
  logic                r_push_user;
  logic [DATA_W-1:0]   r_push_data;
  logic                r_image_end;
  logic [15:0]         r_frame_cnt;
  logic                r_overflow;
  logic                r_size_err;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_overflow_set;
  logic [BEAT_W-1:0]   w_fifo_rd;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_pixel) begin
    if (clk_pixel_reset) r_state <= ST_IDLE;
    else                 r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:         if (arm)   w_state_nxt = ST_WAIT_FV_LOW;
      ST_WAIT_FV_LOW:  if (!fval) w_state_nxt = ST_WAIT_FV_HIGH;
      ST_WAIT_FV_HIGH: if (fval)  w_state_nxt = ST_CAPTURE;
      ST_CAPTURE:      if (!fval) w_state_nxt = ST_FLUSH;
      ST_FLUSH:        w_state_nxt = cfg_continuous ? ST_WAIT_FV_LOW : ST_IDLE;
      default:         w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_capture = (r_state == ST_CAPTURE);
    w_flush      = (r_state == ST_FLUSH);
    w_sof        = (r_state == ST_WAIT_FV_HIGH) && fval;
    w_fval_fall  = w_in_capture && !fval;
    w_lval_fall  = w_in_capture && r_lval_d && !lval;
    w_valid_pix  = w_in_capture && fval && lval && dval;
  end

  // ---------------------------------------------------------------- ROI
`ifdef CLINK_PACKER_ROI_EN
  logic [COORD_W:0] w_x;
  logic [COORD_W:0] w_y;
  assign w_x = {1'b0, r_pix_cnt};
  assign w_y = {1'b0, r_line_cnt};
  assign w_roi_hit = (w_x >= {1'b0, cfg_roi_x}) &&
                     (w_x <  ({1'b0, cfg_roi_x} + {1'b0, cfg_roi_w})) &&
                     (w_y >= {1'b0, cfg_roi_y}) &&
                     (w_y <  ({1'b0, cfg_roi_y} + {1'b0, cfg_roi_h}));
`else
  logic w_roi_unused;
  assign w_roi_unused = ^{cfg_roi_x, cfg_roi_y, cfg_roi_w, cfg_roi_h};
  assign w_roi_hit    = 1'b1;
`endif

  assign w_accept = w_valid_pix && w_roi_hit;

  // ---------------------------------------------------------------- geometry
  always_ff @(posedge clk_pixel) begin
    if (clk_pixel_reset) begin
      r_lval_d   <= 1'b0;
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else begin
      r_lval_d <= lval;
      if (!w_in_capture) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
      end else if (w_lval_fall) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= r_line_cnt + 1'b1;
      end else if (w_valid_pix) begin
        r_pix_cnt  <= r_pix_cnt + COORD_W'(TAPS);
      end
    end
  end

  // A line ending on the same cycle as the frame still counts toward the height.
  assign w_lines    = r_line_cnt + {{(COORD_W-1){1'b0}}, w_lval_fall};
  assign w_size_set = (w_lval_fall && (r_pix_cnt != cfg_width)) ||
                      (w_fval_fall && (w_lines != cfg_height));

  // ---------------------------------------------------------------- packing
  always_comb begin
    w_pack_nxt = r_pack;
    for (int t = 0; t < TAPS; t++) begin
      w_pack_nxt[(int'(r_slot) + t)*PIX_CONT_W +: PIX_CONT_W] =
        PIX_CONT_W'(pix_data[t*PIXEL_W +: PIXEL_W]);
    end
  end

  assign w_fill = w_accept && ((int'(r_slot) + TAPS) == PPB);

  always_ff @(posedge clk_pixel) begin
    if (clk_pixel_reset || w_flush) begin
      r_pack <= '0;
      r_slot <= '0;
    end else if (w_accept) begin
      r_pack <= w_fill ? '0 : w_pack_nxt;
      r_slot <= w_fill ? '0 : r_slot + SLOT_W'(TAPS);
    end
  end

  // One full beat is always held back so the final one can be tagged with tlast.
  always_comb begin
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_push_data = r_hold;
    if (w_fill) begin
      w_push = r_hold_vld;
    end else if (w_flush) begin
      if (r_slot != '0) begin
        w_push = 1'b1;
        if (!r_hold_vld) begin
          w_push_data = r_pack;
          w_push_last = 1'b1;
        end
      end else if (r_hold_vld) begin
        w_push      = 1'b1;
        w_push_last = 1'b1;
      end
    end else if (r_tail) begin
      w_push      = 1'b1;
      w_push_last = 1'b1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (clk_pixel_reset) begin
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
      r_tail      <= 1'b0;
      r_first     <= 1'b0;
      r_push      <= 1'b0;
      r_push_last <= 1'b0;
      r_push_user <= 1'b0;
      r_push_data <= '0;
      r_image_end <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_fill) begin
        r_hold     <= w_pack_nxt;
        r_hold_vld <= 1'b1;
      end else if (w_flush) begin
        if ((r_slot != '0) && r_hold_vld) begin
          r_hold <= r_pack;
          r_tail <= 1'b1;
        end else begin
          r_hold_vld <= 1'b0;
        end
      end else if (r_tail) begin
        r_hold_vld <= 1'b0;
        r_tail     <= 1'b0;
      end

      if (w_sof)       r_first <= 1'b1;
      else if (w_push) r_first <= 1'b0;

      r_push      <= w_push;
      r_push_last <= w_push_last;
      r_push_user <= r_first;
      r_push_data <= w_push_data;
      r_image_end <= w_push && w_push_last;
      if (w_push && w_push_last) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------- flags
  assign w_overflow_set = r_push && w_fifo_full && !(m_axis_tvalid && m_axis_tready);

  always_ff @(posedge clk_pixel) begin
    if (clk_pixel_reset) begin
      r_overflow <= 1'b0;
      r_size_err <= 1'b0;
    end else begin
      if (arm) begin
        r_overflow <= 1'b0;
        r_size_err <= 1'b0;
      end
      if (w_overflow_set) r_overflow <= 1'b1;
      if (w_size_set)     r_size_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- output FIFO
  clink_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_pixel),
    .rst     (clk_pixel_reset),
    .wr_en   (r_push),
    .wr_data ({r_push_user, r_push_last, r_push_data}),
    .full    (w_fifo_full),
    .rd_en   (m_axis_tready),
    .rd_data (w_fifo_rd),
    .empty   (w_fifo_empty)
  );

  assign m_axis_tdata  = w_fifo_rd[DATA_W-1:0];
  assign m_axis_tlast  = w_fifo_rd[DATA_W];
  assign m_axis_tuser  = w_fifo_rd[DATA_W+1];
  assign m_axis_tvalid = !w_fifo_empty;
  assign image_end     = r_image_end;
  assign frame_cnt     = r_frame_cnt;
  assign overflow      = r_overflow;
  assign size_err      = r_size_err;
  // Beats still in the holding/push stage keep busy asserted across the FLUSH->IDLE step.
  assign busy          = (r_state != ST_IDLE) || !w_fifo_empty || r_push || r_hold_vld;

endmodule

`default_nettype wire
